// File: rtl/counter_slot_sched.sv
// counter_slot_sched: round-robin sequencer that shares one CW-bit delay
// counter between N_REQ requesters. The winner's delay is loaded, the
// counter runs from 0 up to that delay, then the winner gets a one-cycle
// done pulse. Dropping req while owning the counter aborts the slot.
//
// Handshake: req[i] is a level request that the requester holds until it
// sees done[i]. It must drop req[i] in the cycle done[i] is high. grant[i]
// marks ownership and stays high from the arbitration edge until the slot
// finishes or is aborted. done[i] is a single-cycle pulse that never
// overlaps grant.
module counter_slot_sched #(
  parameter int N_REQ = 4,
  parameter int CW    = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*CW-1:0]   delay,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic                  busy,
  output logic [CW-1:0]         count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SW = IW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [N_REQ-1:0] GRANT_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [CW-1:0] target;

  logic [IW-1:0] pick;
  logic          pick_valid;
  logic [SW-1:0] sum;
  logic [IW-1:0] owner_next;
  logic [CW-1:0] owner_delay;
  logic          owner_req;

  // Round-robin search from ptr upward with wrap. The loop runs from the
  // farthest candidate down to ptr itself so the nearest set bit wins.
  always_comb begin
    pick       = ptr;
    pick_valid = 1'b0;
    sum        = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      if (req[sum[IW-1:0]]) begin
        pick       = sum[IW-1:0];
        pick_valid = 1'b1;
      end
    end
  end

  // Delay field belonging to the current owner, selected with constant slices.
  always_comb begin
    owner_delay = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IW'(i)) owner_delay = delay[i*CW +: CW];
    end
  end

  assign owner_req  = req[owner];
  assign owner_next = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy       = (state != S_IDLE);

  // Slot sequencer: arbitrate, load the delay, count, then pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      owner  <= '0;
      ptr    <= '0;
      target <= '0;
      count  <= '0;
      grant  <= '0;
      done   <= '0;
    end else begin
      done <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            owner <= pick;
            grant <= GRANT_ONE << pick;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!owner_req) begin
            grant <= '0;
            ptr   <= owner_next;
            state <= S_IDLE;
          end else begin
            target <= owner_delay;
            count  <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (!owner_req) begin
            grant <= '0;
            ptr   <= owner_next;
            state <= S_IDLE;
          end else if (count == target) begin
            // grant is one-hot on the owner, so it doubles as the done mask.
            done  <= grant;
            grant <= '0;
            state <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          ptr   <= owner_next;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
